io_responder: RTL and testbench

Memory-mapped I/O responder on the CPU byte bus. It decodes `mem_a[17:16]==2'b11` and serves the UART data port at 0x30000 and the cycle counter / program-stop port at 0x30004. Transmit bytes are buffered in an internal FIFO, and the block drives `io_buffer_full` back to the CPU. It sits beside the 128 KB RAM, and the top-level read mux selects `io_rdata` for I/O addresses.

---
 rtl/io_pkg.sv | 20 ++
 rtl/io_tx_fifo.sv | 71 +++++++
 rtl/io_responder.sv | 111 +++++++++++
 tb/tb_io_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Decode constants shared by the memory-mapped I/O responder and its sub-blocks.
// Pure declarations, no logic.
// No flow control.
package io_pkg;

  localparam logic [1:0] IO_SEL     = 2'b11;

  localparam logic [2:0] OFF_UART   = 3'd0;
  localparam logic [2:0] OFF_CNT    = 3'd4;
  localparam logic [2:0] OFF_CNT_B1 = 3'd5;
  localparam logic [2:0] OFF_CNT_B2 = 3'd6;
  localparam logic [2:0] OFF_CNT_B3 = 3'd7;

  localparam logic [7:0] HALT_BYTE  = 8'h00;

  function automatic logic io_selected(input logic [1:0] region);
    return region == IO_SEL;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO for the UART transmit path with a registered almost-full flag.
// Push visible one cycle later; dout is the head entry, forced to 0 while empty.
// A push into a full FIFO is dropped and flagged on overflow; pop of empty is ignored.
module io_tx_fifo #(
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO drops the push even when a pop frees a slot in the same cycle.
  assign do_push  = push && !full;
  assign overflow = push && full;
  assign dout     = empty ? 8'h00 : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count_nxt;
      almost_full <= (count_nxt >= (AW+1)'(ALMOST_FULL_LEVEL));
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped UART data port and cycle-counter/program-stop port on the CPU byte bus.
// Reads return one cycle after the address; writes reach the tx FIFO one cycle later.
// CPU is throttled through io_buffer_full with FULL_MARGIN slack; tx drains on tx_valid && tx_ready.
module io_responder
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  io_rdata,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow,
  output logic        program_end
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [2:0]    off;
  logic          rd_en;
  logic          wr_en;
  logic          halt_wr;
  logic          push;
  logic [7:0]    push_byte;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [31:0]   cnt;
  logic [31:0]   snap;
  logic          halted;
  logic          unused_ok;

  assign sel   = rst_in && io_selected(mem_a[17:16]);
  assign off   = mem_a[2:0];
  assign rd_en = sel && !mem_wr;
  // After the stop port is written the CPU can no longer feed the tx stream.
  assign wr_en = sel && mem_wr && !halted;

  assign halt_wr   = wr_en && (off == OFF_CNT);
  assign push      = halt_wr || (wr_en && (off == OFF_UART) && (mem_dout != 8'h00));
  assign push_byte = halt_wr ? HALT_BYTE : mem_dout;

  assign rx_pop      = rd_en && (off == OFF_UART) && rx_valid;
  assign tx_valid    = !fifo_empty;
  // No push is possible once halted, so an empty FIFO stays empty until reset.
  assign program_end = halted && fifo_empty;

  assign unused_ok = ^{mem_a[31:18], mem_a[15:3], fifo_full, fifo_count};

  io_tx_fifo #(
    .DEPTH             (FIFO_DEPTH),
    .ALMOST_FULL_LEVEL (FIFO_DEPTH - FULL_MARGIN)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push        (push),
    .pop         (tx_valid && tx_ready),
    .din         (push_byte),
    .dout        (tx_data),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .overflow    (fifo_ovf),
    .almost_full (io_buffer_full)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt         <= 32'd0;
      snap        <= 32'd0;
      halted      <= 1'b0;
      tx_overflow <= 1'b0;
      io_rdata    <= 8'h00;
    end else begin
      cnt <= cnt + 32'd1;
      if (fifo_ovf) begin
        tx_overflow <= 1'b1;
      end
      if (halt_wr) begin
        halted <= 1'b1;
      end
      if (rd_en) begin
        // Byte 4 latches the whole counter so bytes 5..7 form a coherent dword.
        unique case (off)
          OFF_UART:   io_rdata <= rx_valid ? rx_data : 8'h00;
          OFF_CNT: begin
            io_rdata <= cnt[7:0];
            snap     <= cnt;
          end
          OFF_CNT_B1: io_rdata <= snap[15:8];
          OFF_CNT_B2: io_rdata <= snap[23:16];
          OFF_CNT_B3: io_rdata <= snap[31:24];
          default:    io_rdata <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed scenarios plus random bus traffic against a queue-based model.
module tb_io_responder;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  io_rdata;
  logic        io_buffer_full;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_overflow;
  logic        program_end;

  io_responder #(.FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .io_rdata       (io_rdata),
    .io_buffer_full (io_buffer_full),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_overflow    (tx_overflow),
    .program_end    (program_end)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the block should hold, kept as a byte queue and plain counters.
  logic [7:0]  mq[$];
  logic [7:0]  obs_stream[$];
  bit          m_halted;
  bit          m_ovf;
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic [7:0]  m_rdata;

  logic [31:0] ra;
  logic [7:0]  rd_byte;
  logic        rw;
  logic        rrv;
  logic        rtr;
  int          tr_bias;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("io_rdata", io_rdata, m_rdata);
    chk("tx_valid", tx_valid, mq.size() > 0);
    chk("tx_data", tx_data, (mq.size() > 0) ? mq[0] : 8'h00);
    chk("io_buffer_full", io_buffer_full, mq.size() >= DEPTH - MARGIN);
    chk("tx_overflow", tx_overflow, m_ovf);
    chk("program_end", program_end, m_halted && mq.size() == 0);
  endtask

  // Drive one bus cycle at posedge+1, check rx_pop before the edge and all outputs after it.
  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic w,
                      input logic rv, input logic [7:0] rd, input logic tr);
    logic       sel;
    logic [2:0] off;
    int         sz;
    logic       push;
    logic [7:0] pb;
    mem_a = a; mem_dout = d; mem_wr = w; rx_valid = rv; rx_data = rd; tx_ready = tr;
    #1;
    sel = (a[17:16] == 2'b11);
    off = a[2:0];
    chk("rx_pop", rx_pop, sel && !w && off == 3'd0 && rv);
    if (tx_valid && tr) obs_stream.push_back(tx_data);

    sz = mq.size();
    push = 1'b0;
    pb = 8'h00;
    if (sel && w && !m_halted) begin
      if (off == 3'd0 && d != 8'h00) begin
        push = 1'b1; pb = d;
      end else if (off == 3'd4) begin
        push = 1'b1; m_halted = 1'b1;
      end
    end
    if (sel && !w) begin
      case (off)
        3'd0: m_rdata = rv ? rd : 8'h00;
        3'd4: begin m_rdata = m_cnt[7:0]; m_snap = m_cnt; end
        3'd5: m_rdata = m_snap[15:8];
        3'd6: m_rdata = m_snap[23:16];
        3'd7: m_rdata = m_snap[31:24];
        default: m_rdata = 8'h00;
      endcase
    end
    if (sz > 0 && tr) void'(mq.pop_front());
    if (push) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else mq.push_back(pb);
    end
    m_cnt = m_cnt + 32'd1;

    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic tr);
    step(32'h0, 8'h00, 1'b0, 1'b0, 8'h00, tr);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic tr);
    step(a, d, 1'b1, 1'b0, 8'h00, tr);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    mem_a = '0; mem_dout = '0; mem_wr = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    mq.delete();
    obs_stream.delete();
    m_halted = 1'b0; m_ovf = 1'b0; m_cnt = 32'd0; m_snap = 32'd0; m_rdata = 8'h00;
    check_outputs();
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_cnt", dut.cnt, 32'd0);
    rst_in = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero writes are skipped on the tx stream.
    do_reset();
    wr(32'h30000, 8'h41, 1'b1);
    wr(32'h30000, 8'h00, 1'b1);
    wr(32'h30000, 8'h42, 1'b1);
    repeat (4) idle(1'b1);
    chk("zero_skip_len", obs_stream.size(), 2);
    if (obs_stream.size() == 2) begin
      chk("zero_skip_b0", obs_stream[0], 8'h41);
      chk("zero_skip_b1", obs_stream[1], 8'h42);
    end

    // Almost-full threshold and overflow with a stalled UART.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wr(32'h30000, 8'h10 + 8'(i), 1'b0);
      if (i == 10) chk("not_full_at_11", io_buffer_full, 1'b0);
    end
    chk("full_at_12", io_buffer_full, 1'b1);
    for (int i = 12; i < 17; i++) wr(32'h30000, 8'h10 + 8'(i), 1'b0);
    chk("ovf_sticky", tx_overflow, 1'b1);
    chk("ovf_count", dut.u_fifo.count, 16);
    repeat (20) idle(1'b1);
    chk("ovf_stream_len", obs_stream.size(), 16);
    if (obs_stream.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("ovf_stream", obs_stream[i], 8'h10 + 8'(i));
    end
    chk("ovf_kept", tx_overflow, 1'b1);

    // Snapshot keeps the dword coherent while the counter runs on.
    do_reset();
    repeat (32'h1234) idle(1'b0);
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("cnt_b0", io_rdata, 8'h34);
    step(32'h30005, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("cnt_b1", io_rdata, 8'h12);
    step(32'h30006, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("cnt_b2", io_rdata, 8'h00);
    step(32'h30007, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("cnt_b3", io_rdata, 8'h00);

    // Counter wrap.
    do_reset();
    idle(1'b0);
    force dut.cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cnt;
    repeat (3) @(posedge clk_in);
    #1;
    chk("cnt_wrap", dut.cnt, 32'h0000_0001);

    // UART receive path.
    do_reset();
    step(32'h30000, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("rx_rdata", io_rdata, 8'h5A);
    step(32'h0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("rx_pop_single", rx_pop, 1'b0);
    step(32'h30000, 8'h00, 1'b0, 1'b0, 8'h77, 1'b0);
    chk("rx_empty_rdata", io_rdata, 8'h00);

    // Halt: later writes are dropped, program_end follows the drain.
    do_reset();
    wr(32'h30000, 8'h43, 1'b0);
    wr(32'h30004, 8'h99, 1'b0);
    wr(32'h30000, 8'h44, 1'b0);
    chk("halt_not_done", program_end, 1'b0);
    repeat (5) idle(1'b1);
    chk("halt_stream_len", obs_stream.size(), 2);
    if (obs_stream.size() == 2) begin
      chk("halt_b0", obs_stream[0], 8'h43);
      chk("halt_b1", obs_stream[1], 8'h00);
    end
    chk("program_end_set", program_end, 1'b1);
    do_reset();
    chk("program_end_clr", program_end, 1'b0);

    // Random traffic against the model.
    tr_bias = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (i % 200 == 0) tr_bias = $urandom_range(0, 4);
      ra = $urandom;
      if ($urandom_range(0, 99) < 75) begin
        ra[17:16] = 2'b11;
      end else if (ra[17:16] == 2'b11) begin
        ra[17] = 1'b0;
      end
      rw = 1'($urandom_range(0, 1));
      if (rw && ra[2:0] == 3'd4 && $urandom_range(0, 49) != 0) ra[2:0] = 3'd0;
      rd_byte = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rrv = 1'($urandom_range(0, 1));
      rtr = ($urandom_range(0, 3) < tr_bias);
      step(ra, rd_byte, rw, rrv, 8'($urandom), rtr);
    end
    repeat (20) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
